// File: rtl/joy_event_fifo.sv
// Debounces a joystick button word and queues press/release events in a show-ahead FIFO.
// The consumer pops the event at the FIFO head with a valid/ready handshake.
module joy_event_fifo #(
    parameter int WIDTH      = 12,
    parameter int DB_CYCLES  = 250000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          RESET,
    input  logic [WIDTH-1:0]              joy_in,
    output logic [WIDTH-1:0]              joy_state,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [4:0]                    ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_N  = (AW + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] sync1, sync2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] prev_state;
    logic [WIDTH-1:0] pend_press, pend_rel;
    logic [WIDTH-1:0] clr_press, clr_rel;
    logic             sel_found, sel_press;
    logic [3:0]       sel_idx;
    logic [4:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, pop, push, drop;

    always_ff @(posedge clk) begin
        if (!RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= joy_in;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DB_CYCLES consecutive samples that differ from joy_state.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            joy_state <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == joy_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    joy_state[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A fresh edge wins over a same-cycle clear so a change is never lost.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            prev_state <= '0;
            pend_press <= '0;
            pend_rel   <= '0;
        end else begin
            prev_state <= joy_state;
            pend_press <= (pend_press & ~clr_press) | (joy_state & ~prev_state);
            pend_rel   <= (pend_rel & ~clr_rel) | (~joy_state & prev_state);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_press = 1'b0;
        sel_idx   = '0;
        clr_press = '0;
        clr_rel   = '0;
        // Scanning downward leaves the lowest pending index selected.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_press[i] || pend_rel[i]) begin
                sel_found = 1'b1;
                sel_press = pend_press[i];
                sel_idx   = 4'(i);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_found && sel_idx == 4'(i)) begin
                clr_press[i] = sel_press;
                clr_rel[i]   = !sel_press;
            end
        end
    end

    assign full = (count == DEPTH_N);
    assign pop  = ev_valid && ev_ready;
    assign push = sel_found && (!full || pop);
    assign drop = sel_found && full && !pop;

    always_ff @(posedge clk) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only visible through count and rd_ptr.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sel_press, sel_idx};
    end

    always_ff @(posedge clk) begin
        if (!RESET)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    assign ev_valid = (count != '0);
    assign ev_data  = ev_valid ? mem[rd_ptr] : 5'd0;
    assign ev_count = count;

endmodule

// File: tb/tb_joy_event_fifo.sv
// Scoreboard bench: a window-of-history debounce model predicts events, a monitor checks every pop.
module tb_joy_event_fifo;

    localparam int WIDTH = 12;
    localparam int DB    = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             RESET = 1'b0;
    logic [WIDTH-1:0] joy_in = '0;
    logic             ev_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] joy_state;
    logic             ev_valid;
    logic [4:0]       ev_data;
    logic [2:0]       ev_count;
    logic             overflow;

    joy_event_fifo #(.WIDTH(WIDTH), .DB_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .RESET(RESET), .joy_in(joy_in), .joy_state(joy_state),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .ev_count(ev_count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a bit flips once the last DB synchronised samples all differ from it.
    logic [WIDTH-1:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_flip;
    logic [WIDTH-1:0] win[$];
    logic [4:0]       exp_q[$];
    bit               drop_ok = 1'b0;
    bit               m_ovf = 1'b0;

    function automatic bit all_differ(input int i);
        for (int j = 0; j < DB; j++)
            if (win[j][i] == m_state[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!RESET) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_ovf = 1'b0;
            win.delete();
            exp_q.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > DB) void'(win.pop_front());
            m_flip = '0;
            if (win.size() == DB)
                for (int i = 0; i < WIDTH; i++) m_flip[i] = all_differ(i);
            m_s2 = m_s1;
            m_s1 = joy_in;
            m_state = m_state ^ m_flip;
            // With the consumer stalled, only the first DEPTH queued events survive.
            for (int i = 0; i < WIDTH; i++) begin
                if (m_flip[i]) begin
                    if (drop_ok && exp_q.size() >= DEPTH) m_ovf = 1'b1;
                    else exp_q.push_back({m_state[i], 4'(i)});
                end
            end
        end
    end

    // Monitor: checks debounced state, head stability under back-pressure, and every pop.
    logic       hold_prev = 1'b0;
    logic [4:0] hold_data = '0;
    logic [4:0] pop_log[$];

    always @(negedge clk) begin
        check("joy_state", 32'(joy_state), 32'(m_state));
        if (!RESET) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(ev_valid), 32'd1);
                check("hold_data", 32'(ev_data), 32'(hold_data));
            end
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got 0x%0h expected none", ev_data);
                end else begin
                    check("event", 32'(ev_data), 32'(exp_q.pop_front()));
                end
                pop_log.push_back(ev_data);
            end
            hold_prev = ev_valid && !ev_ready;
            hold_data = ev_data;
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ev_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int p0;
    int waited;
    logic [WIDTH-1:0] mask;

    initial begin
        tick(3);
        check("rst_state", 32'(joy_state), 32'd0);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_data", 32'(ev_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        RESET = 1'b1;
        ev_ready = 1'b1;
        tick(2);

        // Bounce, then a steady press
        p0 = pop_log.size();
        for (int t = 0; t < 12; t++) begin
            joy_in[0] = ~joy_in[0];
            tick(5);
        end
        joy_in[0] = 1'b1;
        tick(DB + 1);
        check("bounce_before", 32'(joy_state[0]), 32'd0);
        tick(1);
        check("bounce_rise", 32'(joy_state[0]), 32'd1);
        tick(1);
        check("bounce_valid_early", 32'(ev_valid), 32'd0);
        tick(1);
        check("bounce_valid", 32'(ev_valid), 32'd1);
        check("bounce_data", 32'(ev_data), 32'b1_0000);
        tick(3);
        check("bounce_pops", pop_log.size() - p0, 32'd1);
        check("bounce_count", 32'(ev_count), 32'd0);

        // Press then release
        p0 = pop_log.size();
        joy_in[4] = 1'b1;
        tick(40);
        joy_in[4] = 1'b0;
        tick(40);
        check("pr_pops", pop_log.size() - p0, 32'd2);
        check("pr_first", 32'(pop_log[p0]), 32'b1_0100);
        check("pr_second", 32'(pop_log[p0 + 1]), 32'b0_0100);
        check("pr_count", 32'(ev_count), 32'd0);
        joy_in = '0;
        tick(30);

        // Simultaneous changes, consumer stalled
        ev_ready = 1'b0;
        joy_in = 12'h00B;
        tick(DB + 3);
        check("sim_valid_early", 32'(ev_valid), 32'd0);
        tick(1);
        check("sim_count1", 32'(ev_count), 32'd1);
        check("sim_head", 32'(ev_data), 32'b1_0000);
        tick(1);
        check("sim_count2", 32'(ev_count), 32'd2);
        tick(1);
        check("sim_count3", 32'(ev_count), 32'd3);
        tick(3);
        check("sim_count_hold", 32'(ev_count), 32'd3);
        p0 = pop_log.size();
        ev_ready = 1'b1;
        tick(5);
        check("sim_order0", 32'(pop_log[p0]), 32'b1_0000);
        check("sim_order1", 32'(pop_log[p0 + 1]), 32'b1_0001);
        check("sim_order2", 32'(pop_log[p0 + 2]), 32'b1_0011);
        joy_in = '0;
        tick(30);
        check("sim_drained", 32'(ev_count), 32'd0);

        // Overflow with six presses
        ev_ready = 1'b0;
        drop_ok = 1'b1;
        joy_in = 12'h03F;
        tick(40);
        check("ovf_count", 32'(ev_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'(m_ovf));
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(ev_data), 32'b1_0000);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        drop_ok = 1'b0;

        // Full FIFO with a pop on the push cycle
        p0 = pop_log.size();
        joy_in = 12'h07F;
        tick(DB + 3);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check("fullpop_count", 32'(ev_count), 32'd4);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        check("fullpop_popped", 32'(pop_log[p0]), 32'b1_0000);
        check("fullpop_head", 32'(ev_data), 32'b1_0001);
        tick(5);
        check("fullpop_stable", 32'(ev_count), 32'd4);
        ev_ready = 1'b1;
        joy_in = '0;
        tick(40);
        check("fullpop_drained", 32'(ev_count), 32'd0);

        // Random presses and glitches, random back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            mask = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            joy_in = joy_in ^ mask;
            if ($urandom_range(0, 2) == 0) begin
                tick($urandom_range(1, 10));
                joy_in = joy_in ^ mask;
            end
            tick($urandom_range(8, 30));
        end
        rand_ready = 1'b0;
        tick(1);
        ev_ready = 1'b1;
        tick(40);
        check("rand_drained", 32'(ev_count), 32'd0);
        check("rand_ovf", 32'(overflow), 32'd0);
        check("rand_exp_empty", 32'(exp_q.size()), 32'd0);

        // Reset with queued events and a held button
        joy_in = '0;
        tick(40);
        ev_ready = 1'b0;
        joy_in = 12'h00B;
        tick(DB + 7);
        check("rst_mid_queued", 32'(ev_count), 32'd3);
        joy_in = 12'h001;
        tick(2);
        RESET = 1'b0;
        tick(2);
        check("rst_mid_state", 32'(joy_state), 32'd0);
        check("rst_mid_valid", 32'(ev_valid), 32'd0);
        check("rst_mid_count", 32'(ev_count), 32'd0);
        check("rst_mid_data", 32'(ev_data), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        RESET = 1'b1;
        ev_ready = 1'b1;
        waited = 0;
        while (ev_valid !== 1'b1 && waited < 30) begin
            tick(1);
            waited++;
        end
        check("rst_repress_in_time", 32'(waited <= DB + 8), 32'd1);
        check("rst_repress_data", 32'(ev_data), 32'b1_0000);
        tick(5);
        check("final_count", 32'(ev_count), 32'd0);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
